// File: rtl/adder4_sequencer_pkg.sv
// Shared types and defaults for the 4-bit adder front-end sequencer.
// The request struct documents the FIFO entry layout: {a, b}, a in the upper half.
package adder4_sequencer_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_PULSE  = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } req_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with extra-bit pointers for full/empty; head is read combinationally.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/adder4_sequencer.sv
// Queues operand pairs and issues them one at a time to the gate-level adder over
// its start/done handshake, returning each sum with mismatch and timeout flags.
module adder4_sequencer
  import adder4_sequencer_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int SETUP_CYCLES = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_mismatch,
  output logic             out_timeout,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_start,
  input  logic             add_done,
  input  logic [WIDTH-1:0] add_s,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   golden_sum;
  logic               d1, d2, d3;
  logic               done_rise;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [2*WIDTH-1:0] fifo_dout;

  assign fifo_pop  = (state == S_IDLE) && !fifo_empty;
  assign in_ready  = !fifo_full;
  assign out_valid = (state == S_RESULT);
  assign busy      = (state != S_IDLE) || !fifo_empty;
  assign done_rise = d2 & ~d3;

  sync_fifo #(.WIDTH(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (fifo_pop),
    .din   ({in_a, in_b}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // d3 tracks d2 continuously, so a done level left high by the previous operation never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
      d3 <= 1'b0;
    end else begin
      d1 <= add_done;
      d2 <= d1;
      d3 <= d2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      add_a        <= '0;
      add_b        <= '0;
      golden_sum   <= '0;
      add_start    <= 1'b0;
      out_z        <= '0;
      out_mismatch <= 1'b0;
      out_timeout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            add_a      <= fifo_dout[2*WIDTH-1:WIDTH];
            add_b      <= fifo_dout[WIDTH-1:0];
            golden_sum <= fifo_dout[2*WIDTH-1:WIDTH] + fifo_dout[WIDTH-1:0];
            cnt        <= '0;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == CW'(SETUP_CYCLES - 1)) begin
            cnt   <= '0;
            state <= S_PULSE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_PULSE: begin
          add_start <= 1'b1;
          state     <= S_WAIT;
        end
        // Abort after TIMEOUT cycles so a dead adder cannot wedge the queue.
        S_WAIT: begin
          if (done_rise) begin
            out_z        <= add_s;
            out_mismatch <= (add_s != golden_sum);
            out_timeout  <= 1'b0;
            add_start    <= 1'b0;
            state        <= S_RESULT;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            out_z        <= '0;
            out_mismatch <= 1'b0;
            out_timeout  <= 1'b1;
            add_start    <= 1'b0;
            state        <= S_RESULT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESULT: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder4_sequencer.sv
// Directed bench for adder4_sequencer with a behavioural adder that can be healthy,
// stuck (done never rises) or faulty (sum xor 1).
module tb_adder4_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a, in_b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_z;
  logic       out_mismatch;
  logic       out_timeout;
  logic [3:0] add_a, add_b;
  logic       add_start;
  logic       add_done;
  logic [3:0] add_s;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int mode = 0;
  logic [3:0] model_sum;

  always #5 clk = ~clk;

  adder4_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_z        (out_z),
    .out_mismatch (out_mismatch),
    .out_timeout  (out_timeout),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_start    (add_start),
    .add_done     (add_done),
    .add_s        (add_s),
    .busy         (busy)
  );

  // Adder model: done drops on start, rises three clocks later (mode 1 never rises).
  initial begin
    add_done = 1'b0;
    add_s    = 4'd0;
    forever begin
      @(posedge add_start);
      add_done = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      model_sum = add_a + add_b;
      if (mode == 2) model_sum = model_sum ^ 4'd1;
      add_s = model_sum;
      if (mode != 1) add_done = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cycles, output bit ok);
    cycles = 0;
    while (!out_valid && cycles < limit) begin
      tick();
      cycles++;
    end
    ok = out_valid;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, out_z, out_mismatch, out_timeout, add_a, add_b, add_start, busy}
        !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b expected %b",
               {in_ready, out_valid, out_z, out_mismatch, out_timeout, add_a, add_b, add_start, busy},
               {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_basic();
    int  cyc;
    bit  ok;
    in_valid = 1'b1;
    in_a = 4'd3;
    in_b = 4'd4;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_busy: got %b expected 1", busy);
    end
    cyc = 0;
    while (!add_start && cyc < 20) begin
      tick();
      cyc++;
    end
    vectors++;
    if (cyc !== 4) begin
      miscompares++;
      $display("[TB] FAIL basic_start_latency: got %0d expected 4", cyc);
    end
    wait_valid(50, cyc, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL basic_valid: got 0 expected 1");
    end
    vectors++;
    if ({out_z, out_mismatch, out_timeout} !== {4'd7, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL basic_result: got z=%0d mm=%b to=%b expected z=7 mm=0 to=0",
               out_z, out_mismatch, out_timeout);
    end
    consume();
  endtask

  task automatic test_wrap();
    int cyc;
    bit ok;
    push(4'd9, 4'd8);
    wait_valid(50, cyc, ok);
    vectors++;
    if (!ok || {out_z, out_mismatch, out_timeout} !== {4'd1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL wrap_result: got valid=%b z=%0d mm=%b to=%b expected valid=1 z=1 mm=0 to=0",
               out_valid, out_z, out_mismatch, out_timeout);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [3:0] av [5] = '{4'd1, 4'd3, 4'd7, 4'd15, 4'd6};
    logic [3:0] bv [5] = '{4'd2, 4'd3, 4'd8, 4'd15, 4'd5};
    logic [3:0] ev [5] = '{4'd3, 4'd6, 4'd15, 4'd14, 4'd11};
    int accepted = 0;
    int cyc;
    bit ok;
    out_ready = 1'b0;
    push(4'd2, 4'd3);
    wait_valid(50, cyc, ok);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a = av[i];
      in_b = bv[i];
      if (i < 4) begin
        if (in_ready) accepted++;
        tick();
      end else begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL fifth_blocked: got in_ready=%b expected 0", in_ready);
        end
      end
    end
    vectors++;
    if (accepted !== 4) begin
      miscompares++;
      $display("[TB] FAIL accepted_count: got %0d expected 4", accepted);
    end
    repeat (3) tick();
    vectors++;
    if ({out_valid, out_z, in_ready} !== {1'b1, 4'd5, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL backpressure_hold: got valid=%b z=%0d in_ready=%b expected valid=1 z=5 in_ready=0",
               out_valid, out_z, in_ready);
    end
    consume();
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_after_pop: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_valid(100, cyc, ok);
      vectors++;
      if (!ok || out_z !== ev[i] || out_mismatch !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL order_%0d: got valid=%b z=%0d mm=%b expected valid=1 z=%0d mm=0",
                 i, out_valid, out_z, out_mismatch, ev[i]);
      end
      repeat (2) tick();
      vectors++;
      if ({out_valid, out_z} !== {1'b1, ev[i]}) begin
        miscompares++;
        $display("[TB] FAIL stable_%0d: got valid=%b z=%0d expected valid=1 z=%0d",
                 i, out_valid, out_z, ev[i]);
      end
      consume();
    end
  endtask

  task automatic test_timeout();
    int cyc;
    bit ok;
    mode = 1;
    push(4'd1, 4'd1);
    push(4'd4, 4'd5);
    cyc = 0;
    while (!add_start && cyc < 20) begin
      tick();
      cyc++;
    end
    wait_valid(400, cyc, ok);
    vectors++;
    if (!ok || cyc !== 255) begin
      miscompares++;
      $display("[TB] FAIL timeout_cycles: got valid=%b after %0d expected valid=1 after 255", out_valid, cyc);
    end
    vectors++;
    if ({out_z, out_mismatch, out_timeout} !== {4'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL timeout_flags: got z=%0d mm=%b to=%b expected z=0 mm=0 to=1",
               out_z, out_mismatch, out_timeout);
    end
    mode = 0;
    consume();
    wait_valid(100, cyc, ok);
    vectors++;
    if (!ok || {out_z, out_mismatch, out_timeout} !== {4'd9, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL after_timeout_next: got valid=%b z=%0d mm=%b to=%b expected valid=1 z=9 mm=0 to=0",
               out_valid, out_z, out_mismatch, out_timeout);
    end
    consume();
  endtask

  task automatic test_mismatch();
    int cyc;
    bit ok;
    mode = 2;
    push(4'd2, 4'd2);
    wait_valid(100, cyc, ok);
    vectors++;
    if (!ok || {out_z, out_mismatch, out_timeout} !== {4'd5, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL mismatch_flag: got valid=%b z=%0d mm=%b to=%b expected valid=1 z=5 mm=1 to=0",
               out_valid, out_z, out_mismatch, out_timeout);
    end
    consume();
    mode = 0;
  endtask

  task automatic test_reset_midop();
    int cyc;
    bit ok;
    push(4'd1, 4'd2);
    push(4'd3, 4'd4);
    push(4'd5, 4'd6);
    cyc = 0;
    while (!add_start && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, out_z, out_mismatch, out_timeout, add_a, add_b, add_start, busy}
        !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL midop_reset: got %b expected %b",
               {in_ready, out_valid, out_z, out_mismatch, out_timeout, add_a, add_b, add_start, busy},
               {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0});
    end
    repeat (12) tick();
    vectors++;
    if ({add_done, out_valid, add_start, busy} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL stray_done_ignored: got done=%b valid=%b start=%b busy=%b expected 1 0 0 0",
               add_done, out_valid, add_start, busy);
    end
    push(4'd6, 4'd7);
    wait_valid(100, cyc, ok);
    vectors++;
    if (!ok || {out_z, out_mismatch, out_timeout} !== {4'd13, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL after_reset_op: got valid=%b z=%0d mm=%b to=%b expected valid=1 z=13 mm=0 to=0",
               out_valid, out_z, out_mismatch, out_timeout);
    end
    consume();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 4'd0;
    in_b      = 4'd0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_timeout();
    test_mismatch();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
